// File: rtl/wb_check_responder.sv
// rtl/wb_check_responder.sv - Wishbone responder with check-signature register bank
module wb_check_responder #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] CHIP_ID     = 32'h5244_0001
) (
    input  logic              mclk,
    input  logic              h_reset_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [15:0]       check_bits_o,
    output logic [15:0]       check_oeb_o
);
    // Word address width: byte-offset bits [1:0] are never decoded.
    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [WA_W-1:0] wadr_q, wadr_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [3:0]      sel_q, sel_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdat_q, rdat_d;
    logic [15:0]     check_q, check_d;
    logic [15:0]     oeb_q, oeb_d;
    logic [31:0]     scratch_q [4];
    logic [31:0]     scratch_d [4];
    logic [7:0]      wrcnt_q, wrcnt_d;

    logic            r_we;
    logic [WA_W-1:0] r_wadr;
    logic [31:0]     r_dat;
    logic [3:0]      r_sel;
    logic [2:0]      r_off;
    logic            mapped;
    logic [31:0]     rd_word;
    logic [31:0]     merged;
    logic            go_resp;
    logic            unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return m;
    endfunction

    // With zero wait states the response is taken straight from the bus,
    // otherwise from the request latched at accept time.
    always_comb begin
        if (state_q == S_IDLE) begin
            r_we   = wbs_we_i;
            r_wadr = wbs_adr_i[ADDR_W-1:2];
            r_dat  = wbs_dat_i;
            r_sel  = wbs_sel_i;
        end else begin
            r_we   = we_q;
            r_wadr = wadr_q;
            r_dat  = wdat_q;
            r_sel  = sel_q;
        end
        r_off  = r_wadr[2:0];
        mapped = ((r_wadr >> 3) == '0);
    end

    // Current contents of the addressed register, used for reads and lane merges.
    always_comb begin
        rd_word = 32'h0;
        case (r_off)
            3'd0: rd_word = {16'h0, check_q};
            3'd1: rd_word = {16'h0, oeb_q};
            3'd2: rd_word = scratch_q[0];
            3'd3: rd_word = scratch_q[1];
            3'd4: rd_word = scratch_q[2];
            3'd5: rd_word = scratch_q[3];
            3'd6: rd_word = {24'h0, wrcnt_q};
            3'd7: rd_word = CHIP_ID;
            default: rd_word = 32'h0;
        endcase
        merged = lane_merge(rd_word, r_dat, r_sel);
    end

    // Transfer FSM plus register commit on the edge that raises ack/err.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wadr_d    = wadr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdat_d    = 32'h0;
        check_d   = check_q;
        oeb_d     = oeb_q;
        scratch_d = scratch_q;
        wrcnt_d   = wrcnt_q;
        go_resp   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d   = wbs_we_i;
                    wadr_d = wbs_adr_i[ADDR_W-1:2];
                    wdat_d = wbs_dat_i;
                    sel_d  = wbs_sel_i;
                    cnt_d  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        go_resp = 1'b1;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_resp) begin
            state_d = S_RESP;
            if (!mapped) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (!r_we) begin
                    rdat_d = rd_word;
                end else if (r_off <= 3'd5) begin
                    wrcnt_d = wrcnt_q + 8'd1;
                    case (r_off)
                        3'd0: check_d      = merged[15:0];
                        3'd1: oeb_d        = merged[15:0];
                        3'd2: scratch_d[0] = merged;
                        3'd3: scratch_d[1] = merged;
                        3'd4: scratch_d[2] = merged;
                        3'd5: scratch_d[3] = merged;
                        default: ;
                    endcase
                end
            end
        end
    end

    // State and register bank, all returning to reset values asynchronously.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            wadr_q  <= '0;
            wdat_q  <= 32'h0;
            sel_q   <= 4'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'h0;
            check_q <= 16'h0;
            oeb_q   <= 16'hFFFF;
            for (int i = 0; i < 4; i++) begin
                scratch_q[i] <= 32'h0;
            end
            wrcnt_q <= 8'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wadr_q    <= wadr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            check_q   <= check_d;
            oeb_q     <= oeb_d;
            scratch_q <= scratch_d;
            wrcnt_q   <= wrcnt_d;
        end
    end

    assign wbs_dat_o    = rdat_q;
    assign wbs_ack_o    = ack_q;
    assign wbs_err_o    = err_q;
    assign check_bits_o = check_q;
    assign check_oeb_o  = oeb_q;

endmodule

// File: tb/tb_wb_check_responder.sv
// tb/tb_wb_check_responder.sv - self-checking bench for wb_check_responder
module tb_wb_check_responder;
    localparam logic [31:0] CHIP_ID = 32'h5244_0001;

    logic        clk, rst_n;
    logic        cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        dut_pick;

    logic        cyc2, stb2, cyc0, stb0;
    logic [31:0] dat2, dat0;
    logic        ack2, ack0, err2, err0;
    logic [15:0] chk2, chk0, oeb2, oeb0;
    logic [31:0] o_dat;
    logic        o_ack, o_err;
    logic [15:0] o_chk, o_oeb;

    assign cyc2  = cyc & ~dut_pick;
    assign stb2  = stb & ~dut_pick;
    assign cyc0  = cyc & dut_pick;
    assign stb0  = stb & dut_pick;
    assign o_dat = dut_pick ? dat0 : dat2;
    assign o_ack = dut_pick ? ack0 : ack2;
    assign o_err = dut_pick ? err0 : err2;
    assign o_chk = dut_pick ? chk0 : chk2;
    assign o_oeb = dut_pick ? oeb0 : oeb2;

    wb_check_responder #(.ADDR_W(8), .WAIT_CYCLES(2), .CHIP_ID(CHIP_ID)) dut (
        .mclk(clk), .h_reset_n(rst_n), .wbs_cyc_i(cyc2), .wbs_stb_i(stb2),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel),
        .wbs_dat_o(dat2), .wbs_ack_o(ack2), .wbs_err_o(err2),
        .check_bits_o(chk2), .check_oeb_o(oeb2)
    );

    wb_check_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .CHIP_ID(CHIP_ID)) dut0 (
        .mclk(clk), .h_reset_n(rst_n), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel),
        .wbs_dat_o(dat0), .wbs_ack_o(ack0), .wbs_err_o(err0),
        .check_bits_o(chk0), .check_oeb_o(oeb0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    // Reference model: register contents as plain variables.
    logic [15:0] m_check, m_oeb;
    logic [31:0] m_scr [4];
    logic [7:0]  m_wrcnt;

    task automatic model_reset();
        m_check = 16'h0;
        m_oeb   = 16'hFFFF;
        for (int i = 0; i < 4; i++) m_scr[i] = 32'h0;
        m_wrcnt = 8'h0;
    endtask

    task automatic model_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic e_err, output logic [31:0] e_dat);
        int          idx;
        logic [31:0] mask, word;
        e_err = (a >= 8'd32);
        e_dat = 32'h0;
        idx   = int'(a) / 4;
        if (!e_err) begin
            case (idx)
                0: word = {16'h0, m_check};
                1: word = {16'h0, m_oeb};
                6: word = {24'h0, m_wrcnt};
                7: word = CHIP_ID;
                default: word = m_scr[idx-2];
            endcase
            if (!w) begin
                e_dat = word;
            end else if (idx <= 5) begin
                mask = 32'h0;
                for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8*b));
                word = (word & ~mask) | (d & mask);
                case (idx)
                    0: m_check = word[15:0];
                    1: m_oeb   = word[15:0];
                    default: m_scr[idx-2] = word;
                endcase
                m_wrcnt = m_wrcnt + 8'd1;
            end
        end
    endtask

    logic        g_ack, g_err;
    logic [31:0] g_dat;
    logic [15:0] g_chk, g_oeb;
    int          g_lat;

    // One bus transfer; returns outputs seen in the response cycle and the latency.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        g_lat = 0; g_ack = 1'b0; g_err = 1'b0; g_dat = 32'h0; g_chk = 16'h0; g_oeb = 16'h0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_ack || o_err) begin
                g_lat = k; g_ack = o_ack; g_err = o_err;
                g_dat = o_dat; g_chk = o_chk; g_oeb = o_oeb;
                break;
            end
        end
        if (g_lat == 0) chk("timeout", 32'(g_lat), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", {30'h0, o_ack, o_err}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic [15:0] exp_chk;
        logic [15:0] exp_oeb;
    } vec_t;

    vec_t vecs [20];

    logic        e_err;
    logic [31:0] e_dat;
    int          n_resp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h1C, 32'h0,        4'hF, 1'b0, 32'h5244_0001, 16'h0000, 16'hFFFF};
        vecs[1]  = '{1'b1, 8'h00, 32'h0000AB60, 4'h3, 1'b0, 32'h0,         16'hAB60, 16'hFFFF};
        vecs[2]  = '{1'b1, 8'h00, 32'h0000AB6A, 4'hF, 1'b0, 32'h0,         16'hAB6A, 16'hFFFF};
        vecs[3]  = '{1'b0, 8'h18, 32'h0,        4'hF, 1'b0, 32'h2,         16'hAB6A, 16'hFFFF};
        vecs[4]  = '{1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,         16'hAB6A, 16'hFFFF};
        vecs[5]  = '{1'b1, 8'h0C, 32'h12345678, 4'h5, 1'b0, 32'h0,         16'hAB6A, 16'hFFFF};
        vecs[6]  = '{1'b0, 8'h0C, 32'h0,        4'hF, 1'b0, 32'hFF34FF78,  16'hAB6A, 16'hFFFF};
        vecs[7]  = '{1'b1, 8'h20, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,         16'hAB6A, 16'hFFFF};
        vecs[8]  = '{1'b0, 8'h20, 32'h0,        4'hF, 1'b1, 32'h0,         16'hAB6A, 16'hFFFF};
        vecs[9]  = '{1'b0, 8'h18, 32'h0,        4'hF, 1'b0, 32'h4,         16'hAB6A, 16'hFFFF};
        vecs[10] = '{1'b0, 8'h00, 32'h0,        4'hF, 1'b0, 32'h0000AB6A,  16'hAB6A, 16'hFFFF};
        vecs[11] = '{1'b1, 8'h1C, 32'h0,        4'hF, 1'b0, 32'h0,         16'hAB6A, 16'hFFFF};
        vecs[12] = '{1'b0, 8'h18, 32'h0,        4'hF, 1'b0, 32'h4,         16'hAB6A, 16'hFFFF};
        vecs[13] = '{1'b1, 8'h04, 32'h0,        4'h3, 1'b0, 32'h0,         16'hAB6A, 16'h0000};
        vecs[14] = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 32'h0,         16'hAB6A, 16'h0000};
        vecs[15] = '{1'b0, 8'h18, 32'h0,        4'hF, 1'b0, 32'h5,         16'hAB6A, 16'h0000};
        vecs[16] = '{1'b1, 8'h10, 32'hAABBCCDD, 4'h0, 1'b0, 32'h0,         16'hAB6A, 16'h0000};
        vecs[17] = '{1'b0, 8'h10, 32'h0,        4'hF, 1'b0, 32'h0,         16'hAB6A, 16'h0000};
        vecs[18] = '{1'b0, 8'h18, 32'h0,        4'hF, 1'b0, 32'h6,         16'hAB6A, 16'h0000};
        vecs[19] = '{1'b0, 8'h0F, 32'h0,        4'hF, 1'b0, 32'hFF34FF78,  16'hAB6A, 16'h0000};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 8'h0; dat = 32'h0; sel = 4'h0; dut_pick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ack", {31'h0, o_ack}, 32'h0);
        chk("reset_err", {31'h0, o_err}, 32'h0);
        chk("reset_dat", o_dat, 32'h0);
        chk("reset_check", {16'h0, o_chk}, 32'h0);
        chk("reset_oeb", {16'h0, o_oeb}, 32'h0000FFFF);

        // Directed vectors on the two-wait-state instance.
        for (int i = 0; i < 20; i++) begin
            model_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, e_err, e_dat);
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
            chk($sformatf("vec%0d_lat", i), 32'(g_lat), 32'd3);
            chk($sformatf("vec%0d_ack", i), {31'h0, g_ack}, {31'h0, ~vecs[i].exp_err});
            chk($sformatf("vec%0d_err", i), {31'h0, g_err}, {31'h0, vecs[i].exp_err});
            if (!vecs[i].we) chk($sformatf("vec%0d_dat", i), g_dat, vecs[i].exp_dat);
            chk($sformatf("vec%0d_check", i), {16'h0, g_chk}, {16'h0, vecs[i].exp_chk});
            chk($sformatf("vec%0d_oeb", i), {16'h0, g_oeb}, {16'h0, vecs[i].exp_oeb});
        end

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic        rw;
            logic [7:0]  ra;
            logic [31:0] rd;
            logic [3:0]  rs;
            rw = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 47));
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            model_xfer(rw, ra, rd, rs, e_err, e_dat);
            xfer(rw, ra, rd, rs);
            chk($sformatf("rnd%0d_lat", i), 32'(g_lat), 32'd3);
            chk($sformatf("rnd%0d_err", i), {30'h0, g_ack, g_err}, {30'h0, ~e_err, e_err});
            if (!rw) chk($sformatf("rnd%0d_dat", i), g_dat, e_dat);
            chk($sformatf("rnd%0d_check", i), {16'h0, g_chk}, {16'h0, m_check});
            chk($sformatf("rnd%0d_oeb", i), {16'h0, g_oeb}, {16'h0, m_oeb});
        end

        // Abort: cyc dropped during WAIT leaves CHECK and WRCNT untouched.
        model_xfer(1'b1, 8'h00, 32'h000000C3, 4'hF, e_err, e_dat);
        xfer(1'b1, 8'h00, 32'h000000C3, 4'hF);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; dat = 32'h5555; sel = 4'hF;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_resp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_ack || o_err) n_resp++;
        end
        chk("abort_no_resp", 32'(n_resp), 32'd0);
        chk("abort_check", {16'h0, o_chk}, 32'h000000C3);
        model_xfer(1'b0, 8'h18, 32'h0, 4'hF, e_err, e_dat);
        xfer(1'b0, 8'h18, 32'h0, 4'hF);
        chk("abort_wrcnt", g_dat, e_dat);

        // Reset asserted in WAIT: outputs clear at once, no late ack.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; dat = 32'h5555; sel = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", {31'h0, o_ack}, 32'h0);
        chk("rst_mid_check", {16'h0, o_chk}, 32'h0);
        chk("rst_mid_oeb", {16'h0, o_oeb}, 32'h0000FFFF);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_resp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_ack || o_err) n_resp++;
        end
        chk("rst_no_resp", 32'(n_resp), 32'd0);
        model_reset();
        xfer(1'b0, 8'h18, 32'h0, 4'hF);
        chk("rst_wrcnt", g_dat, 32'h0);

        // 256 committed writes wrap WRCNT back to zero.
        for (int i = 0; i < 256; i++) begin
            model_xfer(1'b1, 8'h08, 32'(i), 4'hF, e_err, e_dat);
            xfer(1'b1, 8'h08, 32'(i), 4'hF);
        end
        model_xfer(1'b0, 8'h18, 32'h0, 4'hF, e_err, e_dat);
        xfer(1'b0, 8'h18, 32'h0, 4'hF);
        chk("wrap_wrcnt_model", g_dat, e_dat);
        chk("wrap_wrcnt", g_dat, 32'h0);
        xfer(1'b0, 8'h08, 32'h0, 4'hF);
        chk("wrap_scratch0", g_dat, 32'h000000FF);

        // Zero-wait-state instance.
        dut_pick = 1'b1;
        xfer(1'b0, 8'h1C, 32'h0, 4'hF);
        chk("w0_id_lat", 32'(g_lat), 32'd1);
        chk("w0_id_dat", g_dat, CHIP_ID);
        xfer(1'b1, 8'h00, 32'h0000AB6A, 4'h3);
        chk("w0_check_lat", 32'(g_lat), 32'd1);
        chk("w0_check", {16'h0, g_chk}, 32'h0000AB6A);
        for (int i = 0; i < 255; i++) xfer(1'b1, 8'h08, 32'(i), 4'hF);
        xfer(1'b0, 8'h18, 32'h0, 4'hF);
        chk("w0_wrap_wrcnt", g_dat, 32'h0);
        xfer(1'b0, 8'h08, 32'h0, 4'hF);
        chk("w0_scratch0", g_dat, 32'h000000FE);
        xfer(1'b1, 8'h24, 32'h1, 4'hF);
        chk("w0_unmapped_err", {30'h0, g_ack, g_err}, 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
